// File: rtl/audio_stream_ctrl.sv
// Audio codec stream controller: paces ADC pops and DAC pushes through a small
// stereo sample FIFO, with mute/attenuation on the DAC side and debug counters.
module audio_stream_ctrl #(
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned PRIME      = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  read_ready,
    input  logic [DATA_W-1:0]     readdata_left,
    input  logic [DATA_W-1:0]     readdata_right,
    input  logic                  write_ready,
    output logic                  read,
    output logic                  write,
    output logic [DATA_W-1:0]     writedata_left,
    output logic [DATA_W-1:0]     writedata_right,
    input  logic                  mute,
    input  logic [2:0]            atten,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic [7:0]            overflow_cnt,
    output logic [7:0]            underflow_cnt
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W  = DEPTH_LOG2;
    localparam int unsigned LVL_W  = DEPTH_LOG2 + 1;
    localparam int unsigned PAIR_W = 2 * DATA_W;

    typedef enum logic {
        R_IDLE,
        R_GAP
    } rd_state_e;

    typedef enum logic [1:0] {
        W_PRIME,
        W_RUN,
        W_GAP
    } wr_state_e;

    rd_state_e          rd_state_q, rd_state_d;
    wr_state_e          wr_state_q, wr_state_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic [DATA_W-1:0]  wl_q, wl_d;
    logic [DATA_W-1:0]  wr_q, wr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [7:0]         ovf_q, ovf_d;
    logic [7:0]         unf_q, unf_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PAIR_W-1:0]  mem_q [DEPTH];
    logic [PAIR_W-1:0]  head;
    logic               push, pop, full, empty;

    // Mute forces silence; otherwise sign-preserving attenuation by shift.
    function automatic logic [DATA_W-1:0] shape(input logic [DATA_W-1:0] s,
                                                 input logic mu,
                                                 input logic [2:0] sh);
        logic signed [DATA_W-1:0] ss;
        ss = $signed(s);
        if (mu) return '0;
        return DATA_W'(ss >>> sh);
    endfunction

    assign head  = mem_q[rd_ptr_q];
    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);

    always_comb begin
        rd_state_d = rd_state_q;
        wr_state_d = wr_state_q;
        read_d     = 1'b0;
        write_d    = 1'b0;
        wl_d       = wl_q;
        wr_d       = wr_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        push       = 1'b0;
        pop        = 1'b0;

        // Read side: pulse once, then let the codec's ready settle for a cycle.
        case (rd_state_q)
            R_IDLE: begin
                if (read_ready) begin
                    read_d     = 1'b1;
                    rd_state_d = R_GAP;
                    if (!full) begin
                        push = 1'b1;
                    end else if (ovf_q != 8'hFF) begin
                        ovf_d = ovf_q + 8'd1;
                    end
                end
            end
            R_GAP:   rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase

        // Write side: wait for PRIME pairs, then drain; an empty FIFO re-primes.
        case (wr_state_q)
            W_PRIME: begin
                if (level_q >= LVL_W'(PRIME)) begin
                    wr_state_d = W_RUN;
                end
            end
            W_RUN: begin
                if (write_ready) begin
                    write_d = 1'b1;
                    if (!empty) begin
                        pop        = 1'b1;
                        wl_d       = shape(head[PAIR_W-1:DATA_W], mute, atten);
                        wr_d       = shape(head[DATA_W-1:0], mute, atten);
                        wr_state_d = W_GAP;
                    end else begin
                        wl_d       = '0;
                        wr_d       = '0;
                        wr_state_d = W_PRIME;
                        if (unf_q != 8'hFF) begin
                            unf_d = unf_q + 8'd1;
                        end
                    end
                end
            end
            W_GAP:   wr_state_d = W_RUN;
            default: wr_state_d = W_PRIME;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            rd_state_q <= R_IDLE;
            wr_state_q <= W_PRIME;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            wl_q       <= '0;
            wr_q       <= '0;
            level_q    <= '0;
            ovf_q      <= '0;
            unf_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            read_q     <= read_d;
            write_q    <= write_d;
            wl_q       <= wl_d;
            wr_q       <= wr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Sample storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {readdata_left, readdata_right};
        end
    end

    assign read            = read_q;
    assign write           = write_q;
    assign writedata_left  = wl_q;
    assign writedata_right = wr_q;
    assign fifo_level      = level_q;
    assign overflow_cnt    = ovf_q;
    assign underflow_cnt   = unf_q;

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Self-checking bench for audio_stream_ctrl: queue-based reference model compared
// every cycle, plus directed literal checks on reset, processing and counters.
module tb_audio_stream_ctrl;

    localparam int unsigned DW    = 24;
    localparam int unsigned DL    = 3;
    localparam int unsigned PR    = 4;
    localparam int          DEPTH = 8;

    logic          CLOCK_50 = 1'b0;
    logic          resetn;
    logic          read_ready;
    logic [DW-1:0] readdata_left;
    logic [DW-1:0] readdata_right;
    logic          write_ready;
    logic          read;
    logic          write;
    logic [DW-1:0] writedata_left;
    logic [DW-1:0] writedata_right;
    logic          mute;
    logic [2:0]    atten;
    logic [DL:0]   fifo_level;
    logic [7:0]    overflow_cnt;
    logic [7:0]    underflow_cnt;

    audio_stream_ctrl #(.DATA_W(DW), .DEPTH_LOG2(DL), .PRIME(PR)) dut (
        .CLOCK_50       (CLOCK_50),
        .resetn         (resetn),
        .read_ready     (read_ready),
        .readdata_left  (readdata_left),
        .readdata_right (readdata_right),
        .write_ready    (write_ready),
        .read           (read),
        .write          (write),
        .writedata_left (writedata_left),
        .writedata_right(writedata_right),
        .mute           (mute),
        .atten          (atten),
        .fifo_level     (fifo_level),
        .overflow_cnt   (overflow_cnt),
        .underflow_cnt  (underflow_cnt)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_cmp = 0;
    int n_bad = 0;
    int rd_pulses = 0;

    // Reference model: a plain queue of pairs plus what the codec last saw.
    logic [2*DW-1:0] q[$];
    logic            m_read, m_write, primed, prev_read, prev_write;
    logic [DW-1:0]   m_wl, m_wr;
    int              m_ovf, m_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Outgoing sample: silence when muted, else floor(sample / 2**a).
    function automatic logic [DW-1:0] shape(input logic [DW-1:0] s, input logic mu, input int a);
        logic signed [DW-1:0] ss;
        int v, d, r;
        if (mu) return '0;
        ss = $signed(s);
        v  = int'(ss);
        d  = 1 << a;
        r  = v / d;
        if (v < 0 && (v % d) != 0) r = r - 1;
        return DW'(r);
    endfunction

    task automatic model_reset();
        q.delete();
        m_read  = 1'b0;
        m_write = 1'b0;
        primed  = 1'b0;
        m_wl    = '0;
        m_wr    = '0;
        m_ovf   = 0;
        m_unf   = 0;
    endtask

    task automatic model_step();
        int          pre;
        logic        nr, nw;
        logic [2*DW-1:0] p;
        if (!resetn) begin
            model_reset();
            return;
        end
        pre = q.size();
        nr  = read_ready && !m_read;
        nw  = 1'b0;
        if (!primed) begin
            if (pre >= int'(PR)) primed = 1'b1;
        end else if (!m_write && write_ready) begin
            nw = 1'b1;
            if (pre > 0) begin
                p    = q.pop_front();
                m_wl = shape(p[2*DW-1:DW], mute, int'(atten));
                m_wr = shape(p[DW-1:0], mute, int'(atten));
            end else begin
                m_wl   = '0;
                m_wr   = '0;
                primed = 1'b0;
                if (m_unf < 255) m_unf++;
            end
        end
        if (nr) begin
            if (pre < DEPTH) q.push_back({readdata_left, readdata_right});
            else if (m_ovf < 255) m_ovf++;
        end
        m_read  = nr;
        m_write = nw;
    endtask

    // Model advances on each rising edge; DUT is compared just after it.
    initial begin
        model_reset();
        prev_read  = 1'b0;
        prev_write = 1'b0;
        forever begin
            @(posedge CLOCK_50);
            model_step();
            #1;
            chk("read",   32'(read),            32'(m_read));
            chk("write",  32'(write),           32'(m_write));
            chk("wdata_l", 32'(writedata_left),  32'(m_wl));
            chk("wdata_r", 32'(writedata_right), 32'(m_wr));
            chk("level",  32'(fifo_level),      32'(q.size()));
            chk("ovf",    32'(overflow_cnt),    32'(m_ovf));
            chk("unf",    32'(underflow_cnt),   32'(m_unf));
            if (prev_read)  chk("read_back2back",  32'(read),  32'd0);
            if (prev_write) chk("write_back2back", 32'(write), 32'd0);
            prev_read  = read;
            prev_write = write;
            if (read) rd_pulses++;
        end
    end

    task automatic do_reset();
        @(negedge CLOCK_50);
        resetn      = 1'b0;
        read_ready  = 1'b0;
        write_ready = 1'b0;
        mute        = 1'b0;
        atten       = 3'd0;
        repeat (2) @(negedge CLOCK_50);
        resetn = 1'b1;
    endtask

    // Offer one ADC pair and hold read_ready until the model sees it popped.
    task automatic adc_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        logic got;
        got = 1'b0;
        @(negedge CLOCK_50);
        readdata_left  = l;
        readdata_right = r;
        read_ready     = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge CLOCK_50);
            #2;
            got = m_read;
        end
        if (!got) chk("adc_pair_timeout", 32'd0, 32'd1);
        @(negedge CLOCK_50);
        read_ready = 1'b0;
    endtask

    initial begin
        int   k;
        logic seen;
        resetn         = 1'b0;
        read_ready     = 1'b1;
        write_ready    = 1'b1;
        readdata_left  = 24'h123456;
        readdata_right = 24'h654321;
        mute           = 1'b0;
        atten          = 3'd0;

        // Reset holds everything quiet even with both sides ready.
        repeat (3) @(negedge CLOCK_50);
        chk("rst_read",  32'(read),          32'd0);
        chk("rst_write", 32'(write),         32'd0);
        chk("rst_wl",    32'(writedata_left), 32'd0);
        chk("rst_level", 32'(fifo_level),    32'd0);
        chk("rst_ovf",   32'(overflow_cnt),  32'd0);
        chk("rst_unf",   32'(underflow_cnt), 32'd0);
        resetn = 1'b1;
        @(posedge CLOCK_50);
        #1;
        chk("first_read_after_rst", 32'(read), 32'd1);

        // Passthrough: L = k*0x100, R = -L, continuous ready on both sides.
        do_reset();
        write_ready = 1'b1;
        read_ready  = 1'b1;
        k = 1;
        seen = 1'b0;
        readdata_left  = DW'(k * 'h100);
        readdata_right = DW'(-(k * 'h100));
        for (int i = 0; i < 80; i++) begin
            @(negedge CLOCK_50);
            if (write && !seen) begin
                chk("pass_first_l", 32'(writedata_left),  32'h000100);
                chk("pass_first_r", 32'(writedata_right), 32'hFFFF00);
                seen = 1'b1;
            end
            if (m_read) k++;
            readdata_left  = DW'(k * 'h100);
            readdata_right = DW'(-(k * 'h100));
        end
        chk("pass_write_seen", 32'(seen), 32'd1);

        // Processing: attenuation by 4, then mute.
        do_reset();
        adc_pair(24'h800000, 24'h000010);
        for (int i = 0; i < 3; i++) adc_pair(DW'($urandom), DW'($urandom));
        repeat (3) @(negedge CLOCK_50);
        atten = 3'd4;
        write_ready = 1'b1;
        @(negedge CLOCK_50);
        write_ready = 1'b0;
        chk("atten_write", 32'(write),           32'd1);
        chk("atten_l",     32'(writedata_left),  32'hF80000);
        chk("atten_r",     32'(writedata_right), 32'h000001);
        chk("atten_level", 32'(fifo_level),      32'd3);
        mute = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        write_ready = 1'b1;
        @(negedge CLOCK_50);
        write_ready = 1'b0;
        chk("mute_write", 32'(write),           32'd1);
        chk("mute_l",     32'(writedata_left),  32'd0);
        chk("mute_r",     32'(writedata_right), 32'd0);
        chk("mute_level", 32'(fifo_level),      32'd2);
        mute  = 1'b0;
        atten = 3'd0;

        // Overflow: DAC stalled, 10 pairs then 300 more.
        do_reset();
        rd_pulses = 0;
        for (int i = 0; i < 10; i++) adc_pair(DW'($urandom), DW'($urandom));
        @(negedge CLOCK_50);
        chk("ovf_level",  32'(fifo_level),   32'd8);
        chk("ovf_cnt",    32'(overflow_cnt), 32'd2);
        chk("ovf_pulses", 32'(rd_pulses),    32'd10);
        for (int i = 0; i < 300; i++) adc_pair(DW'($urandom), DW'($urandom));
        @(negedge CLOCK_50);
        chk("ovf_sat", 32'(overflow_cnt), 32'd255);

        // Underflow and re-prime.
        do_reset();
        write_ready = 1'b1;
        for (int i = 0; i < 4; i++) adc_pair(DW'($urandom), DW'($urandom));
        for (int i = 0; i < 50 && underflow_cnt == 8'd0; i++) @(negedge CLOCK_50);
        chk("unf_cnt",   32'(underflow_cnt), 32'd1);
        chk("unf_level", 32'(fifo_level),    32'd0);
        repeat (10) @(negedge CLOCK_50);
        chk("unf_hold", 32'(underflow_cnt), 32'd1);
        for (int i = 0; i < 4; i++) adc_pair(DW'($urandom), DW'($urandom));
        repeat (6) @(negedge CLOCK_50);

        // Simultaneous push/pop at level 3, then async reset during the gap.
        do_reset();
        for (int i = 0; i < 4; i++) adc_pair(DW'($urandom), DW'($urandom));
        repeat (3) @(negedge CLOCK_50);
        write_ready = 1'b1;
        @(negedge CLOCK_50);
        write_ready = 1'b0;
        chk("sim_pre_level", 32'(fifo_level), 32'd3);
        repeat (3) @(negedge CLOCK_50);
        readdata_left  = DW'($urandom);
        readdata_right = DW'($urandom);
        read_ready  = 1'b1;
        write_ready = 1'b1;
        @(posedge CLOCK_50);
        #1;
        chk("sim_read",  32'(read),       32'd1);
        chk("sim_write", 32'(write),      32'd1);
        chk("sim_level", 32'(fifo_level), 32'd3);
        @(negedge CLOCK_50);
        read_ready = 1'b0;
        resetn = 1'b0;
        #1;
        chk("arst_write", 32'(write),          32'd0);
        chk("arst_read",  32'(read),           32'd0);
        chk("arst_wl",    32'(writedata_left), 32'd0);
        chk("arst_level", 32'(fifo_level),     32'd0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        repeat (10) @(negedge CLOCK_50);

        // Randomized traffic with varying ready densities.
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLOCK_50);
            read_ready     = ($urandom_range(0, 3) != 0);
            write_ready    = ((i / 500) % 3 == 0) ? ($urandom_range(0, 3) == 0) :
                             ((i / 500) % 3 == 1) ? ($urandom_range(0, 3) != 0) :
                                                    1'($urandom_range(0, 1));
            readdata_left  = DW'($urandom);
            readdata_right = DW'($urandom);
            mute           = ($urandom_range(0, 7) == 0);
            atten          = 3'($urandom_range(0, 7));
        end
        @(negedge CLOCK_50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
